// File: rtl/handshake_sink_if.sv
// handshake_sink_if
//   Valid/ready beat channel between a handshake master and the sink.
//   Signals:
//     s_valid  master has a beat on s_data
//     s_ready  slave can accept a beat this edge
//     s_data   beat payload, DATA_BITS wide
//   Modports:
//     master  drives s_valid/s_data, observes s_ready
//     slave   observes s_valid/s_data, drives s_ready
interface handshake_sink_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/handshake_sink.sv
// handshake_sink
//   Receive endpoint of a valid/ready channel. Accepted beats land in a
//   first-word-fall-through FIFO that local logic drains via rd_en.
//   With ALWAYS_READY=0 the sink also drops ready one cycle in every
//   READY_PERIOD, giving a deterministic "not always ready" slave.
//   Ports:
//     clk, rst    rising-edge clock, asynchronous active-high reset
//     s           slave side of the handshake channel (s_ready registered)
//     rd_en       pop the head entry
//     rd_valid    FIFO holds at least one beat
//     rd_data     head entry, meaningful only while rd_valid=1
//     count       current occupancy, 0..DEPTH
//     beat_count  total accepted beats, wraps at 2^32
//     underflow   sticky flag: rd_en seen while empty
module handshake_sink #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 4,
  parameter int ALWAYS_READY = 1,
  parameter int READY_PERIOD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  handshake_sink_if.slave              s,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [DATA_BITS-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  beat_count,
  output logic                         underflow
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int THR_BITS = $clog2(READY_PERIOD);

  localparam logic [CNT_BITS-1:0] DEPTH_C    = CNT_BITS'(DEPTH);
  localparam logic [THR_BITS-1:0] THR_LAST_C = THR_BITS'(READY_PERIOD - 1);

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [THR_BITS-1:0] thr_q, thr_d;
  logic                ready_q, ready_d;
  logic [31:0]         beat_count_q, beat_count_d;
  logic                underflow_q, underflow_d;

  logic push;
  logic pop;
  logic empty;
  logic gate_next;

  assign empty = (count_q == '0);
  // ready is registered, so a push can never overrun a full FIFO
  assign push  = s.s_valid && ready_q;
  assign pop   = rd_en && !empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_count_d = beat_count_q;
    underflow_d  = underflow_q;
    gate_next    = 1'b1;

    if (push) begin
      wr_ptr_d     = wr_ptr_q + PTR_BITS'(1);
      beat_count_d = beat_count_q + 32'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase

    // free-running throttle phase, anchored to reset release
    thr_d = (thr_q == THR_LAST_C) ? '0 : thr_q + THR_BITS'(1);

    if (ALWAYS_READY == 0) begin
      gate_next = (thr_d != THR_LAST_C);
    end

    // look ahead one cycle so the registered ready is correct when it lands
    ready_d = (count_d < DEPTH_C) && gate_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      thr_q        <= '0;
      ready_q      <= 1'b0;
      beat_count_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      thr_q        <= thr_d;
      ready_q      <= ready_d;
      beat_count_q <= beat_count_d;
      underflow_q  <= underflow_d;
    end
  end

  // storage is deliberately left out of reset; occupancy gates its use
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s.s_data;
    end
  end

  assign s.s_ready  = ready_q;
  assign rd_valid   = !empty;
  assign rd_data    = mem[rd_ptr_q];
  assign count      = count_q;
  assign beat_count = beat_count_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_handshake_sink.sv
// tb_handshake_sink
//   Drives two sinks side by side: dut_a (ALWAYS_READY=1) and dut_b
//   (ALWAYS_READY=0, READY_PERIOD=4). A reference model of each sink keeps
//   an expected-data queue that is filled on accepted beats and drained
//   when the sink pops, plus expected ready/count/flags.
module tb_handshake_sink;

  logic clk;
  logic rst;

  logic [1:0] sv;
  logic [1:0] re;
  logic [7:0] sd [2];

  handshake_sink_if #(.DATA_BITS(8)) a_if ();
  handshake_sink_if #(.DATA_BITS(8)) b_if ();

  logic [7:0]  o_data  [2];
  logic [2:0]  o_count [2];
  logic [31:0] o_beats [2];
  logic [1:0]  o_valid;
  logic [1:0]  o_under;
  logic [1:0]  o_ready;

  assign a_if.s_valid = sv[0];
  assign a_if.s_data  = sd[0];
  assign b_if.s_valid = sv[1];
  assign b_if.s_data  = sd[1];
  assign o_ready[0]   = a_if.s_ready;
  assign o_ready[1]   = b_if.s_ready;

  handshake_sink #(
    .DATA_BITS(8), .DEPTH(4), .ALWAYS_READY(1), .READY_PERIOD(4)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .s         (a_if.slave),
    .rd_en     (re[0]),
    .rd_valid  (o_valid[0]),
    .rd_data   (o_data[0]),
    .count     (o_count[0]),
    .beat_count(o_beats[0]),
    .underflow (o_under[0])
  );

  handshake_sink #(
    .DATA_BITS(8), .DEPTH(4), .ALWAYS_READY(0), .READY_PERIOD(4)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .s         (b_if.slave),
    .rd_en     (re[1]),
    .rd_valid  (o_valid[1]),
    .rd_data   (o_data[1]),
    .count     (o_count[1]),
    .beat_count(o_beats[1]),
    .underflow (o_under[1])
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_count [2];
  int m_beats [2];
  int m_thr   [2];
  bit m_ready [2];
  bit m_under [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] head(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic resetModels();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0;
      m_beats[i] = 0;
      m_thr[i]   = 0;
      m_ready[i] = 1'b0;
      m_under[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
    cyc = 0;
  endtask

  // advance the reference model of sink i across one active edge
  task automatic modelEdge(input int i);
    bit push;
    bit pop;
    bit gate;
    push = sv[i] && m_ready[i];
    pop  = re[i] && (m_count[i] != 0);
    if (re[i] && m_count[i] == 0) m_under[i] = 1'b1;
    if (pop) begin
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    if (push) begin
      if (i == 0) q0.push_back(sd[i]);
      else        q1.push_back(sd[i]);
    end
    m_count[i] = m_count[i] + int'(push) - int'(pop);
    m_beats[i] = m_beats[i] + int'(push);
    m_thr[i]   = (m_thr[i] == 3) ? 0 : m_thr[i] + 1;
    gate       = (i == 0) ? 1'b1 : (m_thr[i] != 3);
    m_ready[i] = (m_count[i] < 4) && gate;
  endtask

  task automatic checkAll(input int i);
    checkOutput($sformatf("s_ready%0d", i),    {31'd0, o_ready[i]}, {31'd0, m_ready[i]});
    checkOutput($sformatf("count%0d", i),      {29'd0, o_count[i]}, m_count[i]);
    checkOutput($sformatf("rd_valid%0d", i),   {31'd0, o_valid[i]}, {31'd0, (m_count[i] != 0)});
    checkOutput($sformatf("beat_count%0d", i), o_beats[i],          m_beats[i]);
    checkOutput($sformatf("underflow%0d", i),  {31'd0, o_under[i]}, {31'd0, m_under[i]});
    if (qsize(i) != 0) begin
      checkOutput($sformatf("head%0d", i), {24'd0, o_data[i]}, {24'd0, head(i)});
    end
  endtask

  // one clock: compare popped data before the edge, then all outputs #1 after
  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      if (!rst && re[i] && m_count[i] != 0) begin
        checkOutput($sformatf("pop_data%0d", i), {24'd0, o_data[i]}, {24'd0, head(i)});
      end
    end
    @(posedge clk);
    if (!rst) begin
      modelEdge(0);
      modelEdge(1);
      cyc++;
    end
    #1;
    checkAll(0);
    checkAll(1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [7:0] stream [8];
  int idx;
  int budget;
  bit acc;

  initial begin
    rst = 1'b1;
    sv  = '0;
    re  = '0;
    sd[0] = '0;
    sd[1] = '0;
    resetModels();
    #1;
    checkAll(0);
    checkAll(1);
    @(negedge clk);
    applyStimulus();
    rst = 1'b0;

    // first edge out of reset only raises ready
    applyStimulus();

    // two back-to-back beats into the always-ready sink
    sv[0] = 1'b1; sd[0] = 8'hA5; applyStimulus();
    sd[0] = 8'hC4;               applyStimulus();
    sv[0] = 1'b0;
    checkOutput("bb_count", {29'd0, o_count[0]}, 32'd2);
    checkOutput("bb_head",  {24'd0, o_data[0]},  32'hA5);
    checkOutput("bb_beats", o_beats[0],          32'd2);
    re[0] = 1'b1; applyStimulus();
    re[0] = 1'b0;
    checkOutput("bb_head2",  {24'd0, o_data[0]},  32'hC4);
    checkOutput("bb_count2", {29'd0, o_count[0]}, 32'd1);
    re[0] = 1'b1; applyStimulus();
    re[0] = 1'b0;

    // fill to full: fifth beat must stall until a pop frees space
    for (int k = 0; k < 4; k++) begin
      sv[0] = 1'b1;
      sd[0] = 8'(k + 1);
      applyStimulus();
    end
    checkOutput("full_ready", {31'd0, o_ready[0]}, 32'd0);
    checkOutput("full_count", {29'd0, o_count[0]}, 32'd4);
    sd[0] = 8'h05;
    applyStimulus();
    checkOutput("stall_count", {29'd0, o_count[0]}, 32'd4);
    re[0] = 1'b1; applyStimulus();
    re[0] = 1'b0;
    checkOutput("refill_ready", {31'd0, o_ready[0]}, 32'd1);
    applyStimulus();
    sv[0] = 1'b0;
    checkOutput("refill_count", {29'd0, o_count[0]}, 32'd4);
    re[0] = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus();
    re[0] = 1'b0;
    checkOutput("drain_count", {29'd0, o_count[0]}, 32'd0);

    // throttled sink: 8 held beats, continuous pops, ready follows the phase
    for (int k = 0; k < 8; k++) stream[k] = 8'h30 + 8'(k);
    idx = 0;
    budget = 0;
    re[1] = 1'b1;
    while (idx < 8 && budget < 40) begin
      sv[1] = 1'b1;
      sd[1] = stream[idx];
      acc = m_ready[1];
      applyStimulus();
      checkOutput("thr_phase", {31'd0, o_ready[1]}, {31'd0, ((cyc % 4) != 3)});
      if (acc) idx++;
      budget++;
    end
    sv[1] = 1'b0;
    checkOutput("thr_sent", idx, 32'd8);
    applyStimulus();
    applyStimulus();
    re[1] = 1'b0;
    checkOutput("thr_beats", o_beats[1],          32'd8);
    checkOutput("thr_empty", {29'd0, o_count[1]}, 32'd0);

    // simultaneous push and pop at count 2
    sv[0] = 1'b1; sd[0] = 8'h11; applyStimulus();
    sd[0] = 8'h22;               applyStimulus();
    sd[0] = 8'h33; re[0] = 1'b1; applyStimulus();
    sv[0] = 1'b0;
    checkOutput("pp_count", {29'd0, o_count[0]}, 32'd2);
    checkOutput("pp_head",  {24'd0, o_data[0]},  32'h22);
    applyStimulus();
    applyStimulus();
    // pop while empty sets the sticky flag
    applyStimulus();
    re[0] = 1'b0;
    checkOutput("uf_set",   {31'd0, o_under[0]}, 32'd1);
    checkOutput("uf_count", {29'd0, o_count[0]}, 32'd0);
    applyStimulus();
    checkOutput("uf_hold",  {31'd0, o_under[0]}, 32'd1);

    // asynchronous reset in the middle of a stream
    sv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sd[0] = 8'h44 + 8'(k * 17);
      applyStimulus();
    end
    sd[0] = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    resetModels();
    checkOutput("ar_ready", {31'd0, o_ready[0]}, 32'd0);
    checkOutput("ar_count", {29'd0, o_count[0]}, 32'd0);
    checkOutput("ar_valid", {31'd0, o_valid[0]}, 32'd0);
    checkOutput("ar_beats", o_beats[0],          32'd0);
    checkOutput("ar_under", {31'd0, o_under[0]}, 32'd0);
    @(negedge clk);
    applyStimulus();
    rst = 1'b0;
    sd[0] = 8'hA5;
    applyStimulus();
    applyStimulus();
    sv[0] = 1'b0;
    checkOutput("rs_beats", o_beats[0],          32'd1);
    checkOutput("rs_head",  {24'd0, o_data[0]},  32'hA5);
    checkOutput("rs_count", {29'd0, o_count[0]}, 32'd1);
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
